// File: rtl/snake_move_ctl.sv
// rtl/snake_move_ctl.sv - snake head game-tick controller (IDLE/RUN/OVER)
//
// Purpose: counts vsync rising edges into move ticks, applies direction
// requests, steps the head across the grid and ends the game on a wall hit.
// Ports:
//   pclk, rst                 pixel clock, synchronous active-high reset
//   vsync_in                  vsync from the timing chain
//   start                     single-cycle start/restart request
//   dir_valid, dir_in         direction request (00 R, 01 U, 10 L, 11 D)
//   frame_*_grid              frame geometry from the background stage
//   head_x_grid, head_y_grid  head position
//   dir_out                   committed direction
//   move_tick                 one-cycle pulse per successful move
//   running, game_over        state decodes
//   moves_count               moves survived, saturating at 1023

module snake_move_ctl #(
    parameter int SPEED_FRAMES = 8
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       vsync_in,
    input  logic       start,
    input  logic       dir_valid,
    input  logic [1:0] dir_in,
    input  logic [6:0] frame_x_inside_grid,
    input  logic [5:0] frame_y_inside_grid,
    input  logic [6:0] frame_x_size_grid,
    input  logic [5:0] frame_y_size_grid,
    output logic [6:0] head_x_grid,
    output logic [5:0] head_y_grid,
    output logic [1:0] dir_out,
    output logic       move_tick,
    output logic       running,
    output logic       game_over,
    output logic [9:0] moves_count
);

    localparam int CNT_W = (SPEED_FRAMES > 1) ? $clog2(SPEED_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPEED_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       head_x_q, head_x_d;
    logic [5:0]       head_y_q, head_y_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       pend_q, pend_d;
    logic             tick_q, tick_d;
    logic [9:0]       moves_q, moves_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vsync_q;

    // Bounds are computed one bit wider than the coordinates so that a step
    // past column/row 0 shows up as a large value rather than wrapping.
    logic [7:0] x_min, x_max, cx, nx;
    logic [6:0] y_min, y_max, cy, ny;
    logic       edge_seen, wall_hit;

    always_comb begin
        x_min = {1'b0, frame_x_inside_grid};
        x_max = x_min + {1'b0, frame_x_size_grid} - 8'd3;
        cx    = x_min + (({1'b0, frame_x_size_grid} - 8'd2) >> 1);
        y_min = {1'b0, frame_y_inside_grid};
        y_max = y_min + {1'b0, frame_y_size_grid} - 7'd3;
        cy    = y_min + (({1'b0, frame_y_size_grid} - 7'd2) >> 1);
    end

    assign edge_seen = vsync_in & ~vsync_q;

    // Candidate next head, always taken from the pending direction latched
    // before this cycle; a request arriving with the edge waits a move.
    always_comb begin
        nx = {1'b0, head_x_q};
        ny = {1'b0, head_y_q};
        case (pend_q)
            2'b00:   nx = {1'b0, head_x_q} + 8'd1;
            2'b01:   ny = {1'b0, head_y_q} - 7'd1;
            2'b10:   nx = {1'b0, head_x_q} - 8'd1;
            default: ny = {1'b0, head_y_q} + 7'd1;
        endcase
    end

    assign wall_hit = (nx < x_min) || (nx > x_max) || (ny < y_min) || (ny > y_max);

    always_comb begin
        state_d  = state_q;
        head_x_d = head_x_q;
        head_y_d = head_y_q;
        dir_d    = dir_q;
        pend_d   = pend_q;
        tick_d   = 1'b0;
        moves_d  = moves_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_RUN: begin
                // Reversal is judged against the committed direction.
                if (dir_valid && (dir_in != (dir_q ^ 2'b10))) begin
                    pend_d = dir_in;
                end
                if (edge_seen) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (wall_hit) begin
                            state_d = ST_OVER;
                        end else begin
                            head_x_d = nx[6:0];
                            head_y_d = ny[5:0];
                            dir_d    = pend_q;
                            tick_d   = 1'b1;
                            if (moves_q != 10'h3FF) begin
                                moves_d = moves_q + 10'd1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                // IDLE tracks the centre; OVER keeps the head where it died.
                cnt_d = '0;
                if (state_q == ST_IDLE) begin
                    head_x_d = cx[6:0];
                    head_y_d = cy[5:0];
                end
                if (start) begin
                    state_d  = ST_RUN;
                    head_x_d = cx[6:0];
                    head_y_d = cy[5:0];
                    dir_d    = 2'b00;
                    pend_d   = 2'b00;
                    moves_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            head_x_q <= cx[6:0];
            head_y_q <= cy[5:0];
            dir_q    <= 2'b00;
            pend_q   <= 2'b00;
            tick_q   <= 1'b0;
            moves_q  <= '0;
            cnt_q    <= '0;
            vsync_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            head_x_q <= head_x_d;
            head_y_q <= head_y_d;
            dir_q    <= dir_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            moves_q  <= moves_d;
            cnt_q    <= cnt_d;
            vsync_q  <= vsync_in;
        end
    end

    assign head_x_grid = head_x_q;
    assign head_y_grid = head_y_q;
    assign dir_out     = dir_q;
    assign move_tick   = tick_q;
    assign running     = (state_q == ST_RUN);
    assign game_over   = (state_q == ST_OVER);
    assign moves_count = moves_q;

endmodule

// File: tb/tb_snake_move_ctl.sv
// tb/tb_snake_move_ctl.sv - self-checking bench for snake_move_ctl

module tb_snake_move_ctl;

    logic       pclk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync_in = 1'b0;
    logic       start = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir_in = 2'b00;
    logic [6:0] frame_x_inside_grid = 7'd13;
    logic [5:0] frame_y_inside_grid = 6'd15;
    logic [6:0] frame_x_size_grid = 7'd40;
    logic [5:0] frame_y_size_grid = 6'd20;
    logic [6:0] head_x_grid;
    logic [5:0] head_y_grid;
    logic [1:0] dir_out;
    logic       move_tick;
    logic       running;
    logic       game_over;
    logic [9:0] moves_count;

    always #5 pclk = ~pclk;

    snake_move_ctl #(.SPEED_FRAMES(2)) dut (
        .pclk                (pclk),
        .rst                 (rst),
        .vsync_in            (vsync_in),
        .start               (start),
        .dir_valid           (dir_valid),
        .dir_in              (dir_in),
        .frame_x_inside_grid (frame_x_inside_grid),
        .frame_y_inside_grid (frame_y_inside_grid),
        .frame_x_size_grid   (frame_x_size_grid),
        .frame_y_size_grid   (frame_y_size_grid),
        .head_x_grid         (head_x_grid),
        .head_y_grid         (head_y_grid),
        .dir_out             (dir_out),
        .move_tick           (move_tick),
        .running             (running),
        .game_over           (game_over),
        .moves_count         (moves_count)
    );

    typedef struct {
        logic       r, s, dv;
        logic [1:0] din;
        logic       vs;
        int         hx, hy, dir, tick, run, over, cnt;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic s, input logic dv, input logic [1:0] din,
                       input logic vs, input int hx, input int hy, input int dir,
                       input int tick, input int run, input int over, input int cnt);
        vec_t v;
        v.r = r; v.s = s; v.dv = dv; v.din = din; v.vs = vs;
        v.hx = hx; v.hy = hy; v.dir = dir; v.tick = tick;
        v.run = run; v.over = over; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic dv,
                         input logic [1:0] din, input logic vs);
        @(negedge pclk);
        rst = r; start = s; dir_valid = dv; dir_in = din; vsync_in = vs;
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string nm, input int hx, input int hy, input int dir,
                       input int tick, input int run, input int over, input int cnt);
        logic [28:0] got, exp;
        got = {head_x_grid, head_y_grid, dir_out, move_tick, running, game_over, moves_count};
        exp = {7'(hx), 6'(hy), 2'(dir), 1'(tick), 1'(run), 1'(over), 10'(cnt)};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got x=%0d y=%0d dir=%0d tick=%0d run=%0d over=%0d cnt=%0d, expected x=%0d y=%0d dir=%0d tick=%0d run=%0d over=%0d cnt=%0d",
                     nm, head_x_grid, head_y_grid, dir_out, move_tick, running, game_over,
                     moves_count, hx, hy, dir, tick, run, over, cnt);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //   r  s  dv din    vs   hx  hy dir tk run ov cnt
        add(1, 0, 0, 2'b00, 0,  32, 24, 0, 0, 0, 0, 0);  // reset
        add(0, 0, 0, 2'b00, 0,  32, 24, 0, 0, 0, 0, 0);
        add(0, 1, 0, 2'b00, 0,  32, 24, 0, 0, 1, 0, 0);  // start
        add(0, 0, 0, 2'b00, 1,  32, 24, 0, 0, 1, 0, 0);  // edge 1
        add(0, 0, 0, 2'b00, 0,  32, 24, 0, 0, 1, 0, 0);
        add(0, 0, 0, 2'b00, 1,  33, 24, 0, 1, 1, 0, 1);  // edge 2: move right
        add(0, 0, 0, 2'b00, 0,  33, 24, 0, 0, 1, 0, 1);
        add(0, 0, 1, 2'b01, 0,  33, 24, 0, 0, 1, 0, 1);  // request up
        add(0, 0, 0, 2'b00, 1,  33, 24, 0, 0, 1, 0, 1);
        add(0, 0, 0, 2'b00, 0,  33, 24, 0, 0, 1, 0, 1);
        add(0, 0, 0, 2'b00, 1,  33, 23, 1, 1, 1, 0, 2);  // move up
        add(0, 0, 0, 2'b00, 0,  33, 23, 1, 0, 1, 0, 2);
        add(0, 0, 1, 2'b00, 0,  33, 23, 1, 0, 1, 0, 2);  // request right
        add(0, 0, 0, 2'b00, 1,  33, 23, 1, 0, 1, 0, 2);
        add(0, 0, 0, 2'b00, 0,  33, 23, 1, 0, 1, 0, 2);
        add(0, 0, 0, 2'b00, 1,  34, 23, 0, 1, 1, 0, 3);
        add(0, 0, 0, 2'b00, 0,  34, 23, 0, 0, 1, 0, 3);
        add(0, 0, 1, 2'b10, 0,  34, 23, 0, 0, 1, 0, 3);  // reversal, ignored
        add(0, 0, 0, 2'b00, 1,  34, 23, 0, 0, 1, 0, 3);
        add(0, 0, 0, 2'b00, 0,  34, 23, 0, 0, 1, 0, 3);
        add(0, 0, 0, 2'b00, 1,  35, 23, 0, 1, 1, 0, 4);
        add(0, 0, 0, 2'b00, 0,  35, 23, 0, 0, 1, 0, 4);
        add(0, 0, 0, 2'b00, 1,  35, 23, 0, 0, 1, 0, 4);
        add(0, 0, 0, 2'b00, 0,  35, 23, 0, 0, 1, 0, 4);
        add(0, 0, 1, 2'b11, 1,  36, 23, 0, 1, 1, 0, 5);  // request with move edge
        add(0, 0, 0, 2'b00, 0,  36, 23, 0, 0, 1, 0, 5);
        add(0, 0, 0, 2'b00, 1,  36, 23, 0, 0, 1, 0, 5);
        add(0, 0, 0, 2'b00, 0,  36, 23, 0, 0, 1, 0, 5);
        add(0, 0, 0, 2'b00, 1,  36, 24, 3, 1, 1, 0, 6);  // deferred down
        add(0, 0, 0, 2'b00, 0,  36, 24, 3, 0, 1, 0, 6);
        add(0, 0, 0, 2'b00, 1,  36, 24, 3, 0, 1, 0, 6);
        add(0, 0, 0, 2'b00, 0,  36, 24, 3, 0, 1, 0, 6);
        add(0, 1, 0, 2'b00, 1,  36, 25, 3, 1, 1, 0, 7);  // start in RUN ignored
        add(0, 0, 0, 2'b00, 0,  36, 25, 3, 0, 1, 0, 7);
        add(0, 0, 0, 2'b00, 1,  36, 25, 3, 0, 1, 0, 7);
        add(0, 0, 0, 2'b00, 0,  36, 25, 3, 0, 1, 0, 7);
        add(1, 0, 1, 2'b00, 1,  32, 24, 0, 0, 0, 0, 0);  // rst beats move edge
        add(0, 0, 0, 2'b00, 0,  32, 24, 0, 0, 0, 0, 0);
        add(0, 0, 0, 2'b00, 1,  32, 24, 0, 0, 0, 0, 0);  // vsync in IDLE
        add(0, 0, 0, 2'b00, 0,  32, 24, 0, 0, 0, 0, 0);
        add(0, 0, 0, 2'b00, 1,  32, 24, 0, 0, 0, 0, 0);
        add(0, 0, 0, 2'b00, 0,  32, 24, 0, 0, 0, 0, 0);
        add(0, 1, 0, 2'b00, 0,  32, 24, 0, 0, 1, 0, 0);  // restart
        add(0, 0, 0, 2'b00, 1,  32, 24, 0, 0, 1, 0, 0);
        add(0, 0, 0, 2'b00, 0,  32, 24, 0, 0, 1, 0, 0);
        add(0, 0, 0, 2'b00, 1,  33, 24, 0, 1, 1, 0, 1);
        add(0, 0, 0, 2'b00, 0,  33, 24, 0, 0, 1, 0, 1);

        foreach (vq[i]) begin
            drive(vq[i].r, vq[i].s, vq[i].dv, vq[i].din, vq[i].vs);
            chk($sformatf("vec%0d", i), vq[i].hx, vq[i].hy, vq[i].dir,
                vq[i].tick, vq[i].run, vq[i].over, vq[i].cnt);
        end

        // Run right into the east wall: 18 moves reach x=50, the 19th is a hit.
        drive(1, 0, 0, 2'b00, 0);
        chk("wall_reset", 32, 24, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 2'b00, 0);
        chk("wall_start", 32, 24, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 19; i++) begin
            drive(0, 0, 0, 2'b00, 1);
            drive(0, 0, 0, 2'b00, 0);
            drive(0, 0, 0, 2'b00, 1);
            if (i <= 18) chk($sformatf("wall_move%0d", i), 32 + i, 24, 0, 1, 1, 0, i);
            else         chk("wall_hit", 50, 24, 0, 0, 0, 1, 18);
            drive(0, 0, 0, 2'b00, 0);
            if (i <= 18) chk($sformatf("wall_idle%0d", i), 32 + i, 24, 0, 0, 1, 0, i);
            else         chk("wall_hit_hold", 50, 24, 0, 0, 0, 1, 18);
        end

        // OVER keeps the head frozen and ignores vsync and requests.
        drive(0, 0, 1, 2'b01, 1);
        drive(0, 0, 0, 2'b00, 0);
        drive(0, 0, 0, 2'b00, 1);
        chk("over_frozen", 50, 24, 0, 0, 0, 1, 18);

        // Restart from OVER.
        drive(0, 1, 0, 2'b00, 0);
        chk("over_restart", 32, 24, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 2'b00, 1);
        drive(0, 0, 0, 2'b00, 0);
        drive(0, 0, 0, 2'b00, 1);
        chk("restart_move", 33, 24, 0, 1, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
